// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcodes, field positions, FSM states, defaults.
package instr_fetch_pkg;

    localparam int PC_W_DEF    = 9;
    localparam int INSTR_W_DEF = 32;

    localparam logic [5:0] OP_NOOP = 6'h00;
    localparam logic [5:0] OP_JMP  = 6'h08;
    localparam logic [5:0] OP_JC   = 6'h09;
    localparam logic [5:0] OP_JAL  = 6'h3B;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 22;
    localparam int RA_HI  = 21;
    localparam int RA_LO  = 18;
    localparam int RB_HI  = 17;
    localparam int RB_LO  = 14;
    localparam int IMM_HI = 13;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register. Flush beats hold; a bubble is all-zeros (decodes as NOOP).
module if_id_reg
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_hold,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc_next,
    output logic [INSTR_W-1:0] o_instr,
    output logic [5:0]         o_opcode,
    output logic [PC_W-1:0]    o_pc_next,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_next;
    logic               r_valid;

    // Capture, hold or bubble the fetched word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr   <= '0;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
        end else if (i_flush || (!i_hold && !i_valid)) begin
            r_instr   <= '0;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
        end else if (!i_hold) begin
            r_instr   <= i_instr;
            r_pc_next <= i_pc_next;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_opcode  = r_instr[OPC_HI:OPC_LO];
    assign o_pc_next = r_pc_next;
    assign o_valid   = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, run/halt/redirect FSM, imem read issue, feeding the IF/ID register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_pc_load,
    input  logic [PC_W-1:0]    i_pc_load_val,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [PC_W-1:0]    i_jump_target,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_branch_target,
    output logic [PC_W-1:0]    o_imem_addr,
    output logic               o_imem_en,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [5:0]         o_id_opcode,
    output logic [INSTR_W-1:0] o_id_instr,
    output logic [PC_W-1:0]    o_id_pc_next,
    output logic               o_id_valid,
    output logic [PC_W-1:0]    o_pc_out
);

    fetch_state_e       r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc, w_pc_nxt;
    logic               r_inflight, w_inflight_nxt;
    logic [PC_W-1:0]    r_inflight_pc, w_inflight_pc_nxt;
    // The word for inflight_pc arrives during the first stalled cycle while the
    // address bus keeps re-reading pc; park it here so it is not lost on resume.
    logic [INSTR_W-1:0] r_skid_data;
    logic               r_skid_vld, w_skid_vld_nxt, w_skid_ld;
    logic               w_if_hold, w_if_flush;
    logic               w_redir;
    logic [PC_W-1:0]    w_redir_tgt;

    assign w_redir     = i_jump | i_branch_taken;
    assign w_redir_tgt = i_jump ? i_jump_target : i_branch_target;

    // Next-state / PC: halt > redirect > stall > advance
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_inflight_nxt    = r_inflight;
        w_inflight_pc_nxt = r_inflight_pc;
        w_skid_vld_nxt    = r_skid_vld;
        w_skid_ld         = 1'b0;
        w_if_hold         = 1'b0;
        w_if_flush        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_if_flush     = 1'b1;
                w_inflight_nxt = 1'b0;
                w_skid_vld_nxt = 1'b0;
                if (i_pc_load) w_pc_nxt = i_pc_load_val;
                if (i_run)     w_state_nxt = S_RUN;
            end
            S_RUN, S_REDIR: begin
                if (!i_run) begin
                    // rewind to the oldest fetch not yet in IF/ID
                    w_state_nxt    = S_IDLE;
                    w_if_flush     = 1'b1;
                    w_inflight_nxt = 1'b0;
                    w_skid_vld_nxt = 1'b0;
                    w_pc_nxt       = r_inflight ? r_inflight_pc : r_pc;
                end else if (w_redir) begin
                    w_state_nxt    = S_REDIR;
                    w_if_flush     = 1'b1;
                    w_inflight_nxt = 1'b0;
                    w_skid_vld_nxt = 1'b0;
                    w_pc_nxt       = w_redir_tgt;
                end else if (r_state == S_RUN && i_stall) begin
                    w_if_hold = 1'b1;
                    if (r_inflight && !r_skid_vld) begin
                        w_skid_ld      = 1'b1;
                        w_skid_vld_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt       = S_RUN;
                    w_pc_nxt          = r_pc + PC_W'(1);
                    w_inflight_nxt    = 1'b1;
                    w_inflight_pc_nxt = r_pc;
                    w_skid_vld_nxt    = 1'b0;
                    w_if_flush        = (r_state == S_REDIR);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_if_flush     = 1'b1;
                w_inflight_nxt = 1'b0;
                w_skid_vld_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and in-flight tracking registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_skid_vld    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_inflight    <= w_inflight_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_skid_vld    <= w_skid_vld_nxt;
        end
    end

    // Skid buffer for the word returned during the first stalled cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_skid_data <= '0;
        else if (w_skid_ld) r_skid_data <= i_imem_data;
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_hold    (w_if_hold),
        .i_flush   (w_if_flush),
        .i_valid   (r_inflight),
        .i_instr   (r_skid_vld ? r_skid_data : i_imem_data),
        .i_pc_next (r_inflight_pc + PC_W'(1)),
        .o_instr   (o_id_instr),
        .o_opcode  (o_id_opcode),
        .o_pc_next (o_id_pc_next),
        .o_valid   (o_id_valid)
    );

    assign o_imem_en   = (r_state != S_IDLE);
    assign o_imem_addr = r_pc;
    assign o_pc_out    = r_pc;

endmodule
